// File: rtl/cpu_mc_pkg.sv
// Shared definitions for the multicycle MIPS control unit: state codes, opcodes,
// datapath mux encodings and the packed control-word payload.
package cpu_mc_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned OP_W    = 6;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC     = 4'd6,
        S_RWB      = 4'd7,
        S_BEQ      = 4'd8,
        S_JUMP     = 4'd9,
        S_IMMEX    = 4'd10,
        S_IMMWB    = 4'd11,
        S_BNE      = 4'd12,
        S_ILLEGAL  = 4'd15
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'h0A;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_SLT   = 2'b11;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal;
    } ctrl_t;

    // DECODE dispatch target for an opcode; anything unsupported traps.
    function automatic state_t dispatch(input logic [OP_W-1:0] op);
        case (op)
            OP_LW, OP_SW:     return S_MEMADR;
            OP_RTYPE:         return S_EXEC;
            OP_ADDI, OP_SLTI: return S_IMMEX;
            OP_BEQ:           return S_BEQ;
            OP_BNE:           return S_BNE;
            OP_J:             return S_JUMP;
            default:          return S_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Moore control decode: maps the current state (plus mem_ready in FETCH and the
// opcode in IMMEX) onto the datapath control word.
module mc_output_decode
    import cpu_mc_pkg::*;
(
    input  state_t          state,
    input  logic            mem_ready,
    input  logic [OP_W-1:0] opcode,
    output ctrl_t           ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMREAD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_RWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_IMMEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = (opcode == OP_SLTI) ? ALUOP_SLT : ALUOP_ADD;
            end
            S_IMMWB: begin
                ctrl.reg_write = 1'b1;
            end
            S_BEQ, S_BNE: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.branch_ne     = (state == S_BNE);
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            S_ILLEGAL: begin
                ctrl.illegal = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS main controller: state register with next-state sequencing;
// control outputs come from mc_output_decode and are forced low during reset.
module multicycle_control_fsm
    import cpu_mc_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [OP_W-1:0]    opcode,
    input  logic               mem_ready,
    output logic [STATE_W-1:0] state,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               branch_ne,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         pc_source,
    output logic               illegal
);

    state_t state_q;
    ctrl_t  dec;
    ctrl_t  ctrl;

    // Memory states hold on mem_ready; unused codes fall back to FETCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            case (state_q)
                S_FETCH:    if (mem_ready) state_q <= S_DECODE;
                S_DECODE:   state_q <= dispatch(opcode);
                S_MEMADR:   state_q <= (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:  if (mem_ready) state_q <= S_MEMWB;
                S_MEMWRITE: if (mem_ready) state_q <= S_FETCH;
                S_EXEC:     state_q <= S_RWB;
                S_IMMEX:    state_q <= S_IMMWB;
                S_ILLEGAL:  state_q <= S_ILLEGAL;
                default:    state_q <= S_FETCH;
            endcase
        end
    end

    mc_output_decode u_decode (
        .state     (state_q),
        .mem_ready (mem_ready),
        .opcode    (opcode),
        .ctrl      (dec)
    );

    // Requests drop in the same cycle reset is seen, even mid-access.
    assign ctrl = reset ? '0 : dec;

    assign state         = state_q;
    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign branch_ne     = ctrl.branch_ne;
    assign i_or_d        = ctrl.i_or_d;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_dst       = ctrl.reg_dst;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign pc_source     = ctrl.pc_source;
    assign illegal       = ctrl.illegal;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: each instruction is expanded into its expected
// state walk (with random memory waits) and every cycle is checked against a control table.
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic [3:0] state;
    logic       pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write;
    logic       ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, illegal;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [17:0] ctrl_vec;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    multicycle_control_fsm dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .state         (state),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .branch_ne     (branch_ne),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .illegal       (illegal)
    );

    assign ctrl_vec = {pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write,
                       ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                       alu_src_b, alu_op, pc_source, illegal};

    // Control word each state should present, written straight from the state table.
    function automatic logic [17:0] spec_ctrl(input int s, input logic rdy, input logic [5:0] op);
        logic pw, pwc, bne, iord, mr, mw, irw, m2r, rd, rw, sa, ill;
        logic [1:0] sb, aop, psrc;
        {pw, pwc, bne, iord, mr, mw, irw, m2r, rd, rw, sa, ill} = '0;
        sb = 2'b00; aop = 2'b00; psrc = 2'b00;
        case (s)
            0:  begin mr = 1'b1; sb = 2'b01; irw = rdy; pw = rdy; end
            1:  sb = 2'b11;
            2:  begin sa = 1'b1; sb = 2'b10; end
            3:  begin mr = 1'b1; iord = 1'b1; end
            4:  begin rw = 1'b1; m2r = 1'b1; end
            5:  begin mw = 1'b1; iord = 1'b1; end
            6:  begin sa = 1'b1; aop = 2'b10; end
            7:  begin rw = 1'b1; rd = 1'b1; end
            8, 12: begin sa = 1'b1; aop = 2'b01; pwc = 1'b1; psrc = 2'b01; bne = (s == 12); end
            9:  begin pw = 1'b1; psrc = 2'b10; end
            10: begin sa = 1'b1; sb = 2'b10; aop = (op == 6'h0A) ? 2'b11 : 2'b00; end
            11: rw = 1'b1;
            15: ill = 1'b1;
            default: ;
        endcase
        return {pw, pwc, bne, iord, mr, mw, irw, m2r, rd, rw, sa, sb, aop, psrc, ill};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    // One clock: drive inputs after the falling edge, then check before the next rising edge.
    task automatic step(input int exp_s, input logic rdy, input logic [5:0] op,
                        input logic rst, input logic chk_state);
        @(negedge clk);
        reset     = rst;
        mem_ready = rdy;
        opcode    = (exp_s == 1 || exp_s == 2 || exp_s == 10) ? op : 6'($urandom);
        #1;
        if (chk_state) check($sformatf("state op=%0h", op), 32'(state), 32'(exp_s));
        check($sformatf("ctrl s=%0d op=%0h rst=%0b", exp_s, op, rst), 32'(ctrl_vec),
              rst ? 32'd0 : 32'(spec_ctrl(exp_s, rdy, op)));
    endtask

    // Walk one instruction; fw/mw are fetch/memory wait counts, negative picks 0..3.
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
        int path[$];
        int waits;
        path = {0, 1};
        case (op)
            6'h23:        path = {path, 2, 3, 4};
            6'h2B:        path = {path, 2, 5};
            6'h00:        path = {path, 6, 7};
            6'h08, 6'h0A: path = {path, 10, 11};
            6'h04:        path = {path, 8};
            6'h05:        path = {path, 12};
            6'h02:        path = {path, 9};
            default:      path = {path, 15, 15, 15, 15};
        endcase
        foreach (path[i]) begin
            if (path[i] == 0)                       waits = (fw < 0) ? int'($urandom_range(0, 3)) : fw;
            else if (path[i] == 3 || path[i] == 5)  waits = (mw < 0) ? int'($urandom_range(0, 3)) : mw;
            else                                    waits = 0;
            for (int w = 0; w <= waits; w++) begin
                if (path[i] == 0 || path[i] == 3 || path[i] == 5)
                    step(path[i], (w == waits), op, 1'b0, 1'b1);
                else
                    step(path[i], 1'($urandom), op, 1'b0, 1'b1);
            end
        end
    endtask

    initial begin
        logic [5:0] legal_ops [8];
        legal_ops = '{6'h23, 6'h2B, 6'h00, 6'h08, 6'h0A, 6'h04, 6'h05, 6'h02};
        reset = 1'b1; mem_ready = 1'b0; opcode = 6'h00;

        step(0, 1'b1, 6'h00, 1'b1, 1'b0);
        step(0, 1'b1, 6'h00, 1'b1, 1'b0);

        run_instr(6'h23, 0, 0);
        run_instr(6'h00, 2, 0);
        run_instr(6'h05, 0, 0);
        run_instr(6'h0A, 0, 0);
        run_instr(6'h08, 1, 0);
        run_instr(6'h04, 0, 0);
        run_instr(6'h02, 0, 0);
        run_instr(6'h2B, 0, 2);
        run_instr(6'h23, 1, 3);

        for (int n = 0; n < 60; n++)
            run_instr(legal_ops[$urandom_range(0, 7)], -1, -1);

        run_instr(6'h3F, 0, 0);
        step(15, 1'b0, 6'h3F, 1'b1, 1'b0);
        step(0, 1'b0, 6'h00, 1'b0, 1'b1);
        step(0, 1'b1, 6'h00, 1'b0, 1'b1);

        step(1, 1'b1, 6'h2B, 1'b0, 1'b1);
        step(2, 1'b1, 6'h2B, 1'b0, 1'b1);
        step(5, 1'b0, 6'h2B, 1'b0, 1'b1);
        step(5, 1'b0, 6'h2B, 1'b1, 1'b0);
        step(0, 1'b0, 6'h00, 1'b0, 1'b1);
        step(0, 1'b1, 6'h00, 1'b0, 1'b1);
        step(1, 1'b1, 6'h00, 1'b0, 1'b1);
        step(6, 1'b1, 6'h00, 1'b0, 1'b1);
        step(7, 1'b1, 6'h00, 1'b0, 1'b1);

        run_instr(6'h0A, -1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
